// File: rtl/endec_interface.sv
// Rate 1/2 (1/3 with ENDEC_RATE3_EN) convolutional encoder and hard-decision Viterbi decoder, K=3 or K=9, 128-bit frames.
// Latency: encoder_done at cycle 128, decoder_done at cycle 256 after the load edge; en low pauses everything, no handshake.
module endec_interface (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         en,
  input  logic         i_code_rate,
  input  logic         i_constr_len,
  input  logic [26:0]  i_gen_poly_flat,
  input  logic [127:0] i_encoder_data_frame,
  input  logic [383:0] i_decoder_data_frame,
  output logic [383:0] o_encoder_data,
  output logic         o_encoder_done,
  output logic [127:0] o_decoder_data,
  output logic         o_decoder_done
);

`ifdef ENDEC_RATE3_EN
  localparam logic RATE3_ON = 1'b1;
`else
  localparam logic RATE3_ON = 1'b0;
`endif

  logic         r_loaded;
  logic [8:0]   r_cyc;
  logic         r_code_rate;
  logic         r_k9;
  logic [26:0]  r_gens;
  logic [127:0] r_enc_frame;
  logic [383:0] r_dec_frame;
  logic [7:0]   r_enc_sr;
  logic [7:0]   r_tb_state;
  logic [383:0] r_enc_out;
  logic         r_enc_done;
  logic [127:0] r_dec_out;
  logic         r_dec_done;
  logic [9:0]   r_pm [256];
  logic [255:0] r_surv [128];

  logic         w_rate3;
  logic [8:0]   w_kmask;
  logic [7:0]   w_top;
  logic [8:0]   w_nstates;
  logic         w_acs_act;
  logic         w_tb_act;
  logic [6:0]   w_step;
  logic [6:0]   w_tb_t;
  logic [8:0]   w_base;
  logic [2:0]   w_nmask;
  logic [2:0]   w_rx;
  logic [2:0]   w_enc_sym;
  logic [9:0]   w_pm_nxt [256];
  logic [255:0] w_dec;
  logic [7:0]   w_st;
  logic [7:0]   w_p0;
  logic [7:0]   w_p1;
  logic [9:0]   w_m0;
  logic [9:0]   w_m1;
  logic [7:0]   w_min_state;
  logic [9:0]   w_min_pm;
  logic [7:0]   w_tb_cur;
  logic         w_tb_bit;
  logic [7:0]   w_tb_prev;

  function automatic logic [2:0] f_sym(input logic [8:0] sr, input logic [26:0] gens, input logic [8:0] kmask);
    logic [2:0] sym;
    sym = '0;
    for (int j = 0; j < 3; j++) sym[j] = ^(gens[9*j +: 9] & kmask & sr);
    return sym;
  endfunction

  // Saturating add keeps never-reached states pinned at 1023.
  function automatic logic [9:0] f_add(input logic [9:0] pm, input logic [2:0] x);
    logic [10:0] sum;
    sum = {1'b0, pm} + {10'd0, x[0]} + {10'd0, x[1]} + {10'd0, x[2]};
    return sum[10] ? 10'h3FF : sum[9:0];
  endfunction

  assign w_rate3   = r_code_rate & RATE3_ON;
  assign w_kmask   = r_k9 ? 9'h1FF : 9'h007;
  assign w_top     = r_k9 ? 8'h80 : 8'h02;
  assign w_nstates = r_k9 ? 9'd256 : 9'd4;
  assign w_nmask   = w_rate3 ? 3'b111 : 3'b011;
  assign w_acs_act = r_loaded && (r_cyc < 9'd128);
  assign w_tb_act  = r_loaded && (r_cyc >= 9'd128) && (r_cyc < 9'd256);
  assign w_step    = r_cyc[6:0];
  assign w_tb_t    = ~r_cyc[6:0];
  assign w_base    = {2'b00, w_step} + {2'b00, w_step} + (w_rate3 ? {2'b00, w_step} : 9'd0);
  assign w_rx      = r_dec_frame[w_base +: 3];
  assign w_enc_sym = f_sym({r_enc_sr, r_enc_frame[w_step]}, r_gens, w_kmask) & w_nmask;

  // Predecessors of state s differ only in the oldest bit; strict compare favours the one with oldest bit 0.
  always_comb begin
    w_dec = '0;
    w_st  = '0;
    w_p0  = '0;
    w_p1  = '0;
    w_m0  = '0;
    w_m1  = '0;
    for (int s = 0; s < 256; s++) begin
      w_st = 8'(s);
      w_p0 = w_st >> 1;
      w_p1 = w_p0 | w_top;
      w_m0 = f_add(r_pm[w_p0], (f_sym({w_p0, w_st[0]}, r_gens, w_kmask) ^ w_rx) & w_nmask);
      w_m1 = f_add(r_pm[w_p1], (f_sym({w_p1, w_st[0]}, r_gens, w_kmask) ^ w_rx) & w_nmask);
      w_pm_nxt[s] = 10'h3FF;
      if ({1'b0, w_st} < w_nstates) begin
        if (w_m1 < w_m0) begin
          w_dec[s]    = 1'b1;
          w_pm_nxt[s] = w_m1;
        end else begin
          w_pm_nxt[s] = w_m0;
        end
      end
    end
  end

  always_comb begin
    w_min_state = '0;
    w_min_pm    = r_pm[0];
    for (int s = 1; s < 256; s++) begin
      if (r_pm[s] < w_min_pm) begin
        w_min_pm    = r_pm[s];
        w_min_state = 8'(s);
      end
    end
  end

  assign w_tb_cur  = (r_cyc == 9'd128) ? w_min_state : r_tb_state;
  assign w_tb_bit  = r_surv[w_tb_t][w_tb_cur];
  assign w_tb_prev = (w_tb_cur >> 1) | (w_tb_bit ? w_top : 8'h00);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_loaded    <= 1'b0;
      r_cyc       <= '0;
      r_code_rate <= 1'b0;
      r_k9        <= 1'b0;
      r_gens      <= '0;
      r_enc_frame <= '0;
      r_dec_frame <= '0;
      r_enc_sr    <= '0;
      r_tb_state  <= '0;
      r_enc_out   <= '0;
      r_enc_done  <= 1'b0;
      r_dec_out   <= '0;
      r_dec_done  <= 1'b0;
      for (int s = 0; s < 256; s++) r_pm[s] <= (s == 0) ? 10'd0 : 10'h3FF;
      for (int t = 0; t < 128; t++) r_surv[t] <= '0;
    end else if (en) begin
      if (!r_loaded) begin
        r_loaded    <= 1'b1;
        r_cyc       <= '0;
        r_code_rate <= i_code_rate;
        r_k9        <= i_constr_len;
        r_gens      <= i_gen_poly_flat;
        r_enc_frame <= i_encoder_data_frame;
        r_dec_frame <= i_decoder_data_frame;
      end else begin
        if (r_cyc < 9'd256) r_cyc <= r_cyc + 9'd1;
        if (w_acs_act) begin
          for (int j = 0; j < 3; j++)
            if (w_nmask[j]) r_enc_out[w_base + 9'(j)] <= w_enc_sym[j];
          r_enc_sr <= {r_enc_sr[6:0], r_enc_frame[w_step]};
          for (int s = 0; s < 256; s++) r_pm[s] <= w_pm_nxt[s];
          r_surv[w_step] <= w_dec;
          if (r_cyc == 9'd127) r_enc_done <= 1'b1;
        end
        if (w_tb_act) begin
          r_dec_out[w_tb_t] <= w_tb_cur[0];
          r_tb_state        <= w_tb_prev;
          if (r_cyc == 9'd255) r_dec_done <= 1'b1;
        end
      end
    end
  end

  assign o_encoder_data = r_enc_out;
  assign o_encoder_done = r_enc_done;
  assign o_decoder_data = r_dec_out;
  assign o_decoder_done = r_dec_done;

endmodule

// File: tb/tb_endec_interface.sv
// Directed bench for endec_interface: hand-computed K=3 vectors, pause/abort timing, K=9 round trip.
module tb_endec_interface;
  logic         sys_clk = 1'b0;
  logic         rst;
  logic         en;
  logic         i_code_rate;
  logic         i_constr_len;
  logic [26:0]  i_gen_poly_flat;
  logic [127:0] i_encoder_data_frame;
  logic [383:0] i_decoder_data_frame;
  logic [383:0] o_encoder_data;
  logic         o_encoder_done;
  logic [127:0] o_decoder_data;
  logic         o_decoder_done;

  int checks = 0;
  int errors = 0;

  endec_interface dut (
    .sys_clk              (sys_clk),
    .rst                  (rst),
    .en                   (en),
    .i_code_rate          (i_code_rate),
    .i_constr_len         (i_constr_len),
    .i_gen_poly_flat      (i_gen_poly_flat),
    .i_encoder_data_frame (i_encoder_data_frame),
    .i_decoder_data_frame (i_decoder_data_frame),
    .o_encoder_data       (o_encoder_data),
    .o_encoder_done       (o_encoder_done),
    .o_decoder_data       (o_decoder_data),
    .o_decoder_done       (o_decoder_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [383:0] conv_enc(input logic [127:0] d, input int k, input int n, input logic [26:0] g);
    logic [383:0] o;
    logic         p;
    o = '0;
    for (int t = 0; t < 128; t++) begin
      for (int j = 0; j < n; j++) begin
        p = 1'b0;
        for (int i = 0; i < k; i++)
          if (t - i >= 0) p = p ^ (g[9*j + i] & d[t - i]);
        o[n*t + j] = p;
      end
    end
    return o;
  endfunction

  task automatic start(input string tag, input logic rate, input logic k9, input logic [26:0] g,
                       input logic [127:0] ef, input logic [383:0] df);
    @(posedge sys_clk); #1;
    rst = 1'b1;
    en  = 1'b1;
    i_code_rate          = rate;
    i_constr_len         = k9;
    i_gen_poly_flat      = g;
    i_encoder_data_frame = ef;
    i_decoder_data_frame = df;
    #1;
    check({tag, "_rst_enc"},      o_encoder_data, '0);
    check({tag, "_rst_enc_done"}, {383'd0, o_encoder_done}, '0);
    check({tag, "_rst_dec"},      {256'd0, o_decoder_data}, '0);
    check({tag, "_rst_dec_done"}, {383'd0, o_decoder_done}, '0);
    @(posedge sys_clk); #1;
    rst = 1'b0;
  endtask

  // Edge e=0 is the load edge; en is held low for pause_len edges after edge pause_at.
  task automatic run_frame(input string tag, input logic [383:0] exp_enc, input logic [127:0] exp_dec,
                           input int pause_at, input int pause_len, input logic [383:0] exp_pause);
    for (int e = 0; e <= 260 + pause_len; e++) begin
      @(posedge sys_clk); #1;
      if (e == 0) begin
        i_encoder_data_frame = ~i_encoder_data_frame;
        i_decoder_data_frame = ~i_decoder_data_frame;
        i_gen_poly_flat      = ~i_gen_poly_flat;
        i_code_rate          = ~i_code_rate;
        i_constr_len         = ~i_constr_len;
      end
      if (pause_len > 0 && e == pause_at) en = 1'b0;
      if (pause_len > 0 && e == pause_at + pause_len) begin
        check({tag, "_paused_enc"}, o_encoder_data, exp_pause);
        check({tag, "_paused_done"}, {383'd0, o_encoder_done}, '0);
        en = 1'b1;
      end
      if (e == 127 + pause_len) check({tag, "_enc_done_early"}, {383'd0, o_encoder_done}, '0);
      if (e == 128 + pause_len) begin
        check({tag, "_enc_done"}, {383'd0, o_encoder_done}, 384'd1);
        check({tag, "_enc_data"}, o_encoder_data, exp_enc);
      end
      if (e == 255 + pause_len) check({tag, "_dec_done_early"}, {383'd0, o_decoder_done}, '0);
      if (e == 256 + pause_len) begin
        check({tag, "_dec_done"}, {383'd0, o_decoder_done}, 384'd1);
        check({tag, "_dec_data"}, {256'd0, o_decoder_data}, {256'd0, exp_dec});
      end
    end
    check({tag, "_hold"}, {o_encoder_data[381:0], o_encoder_done, o_decoder_done},
          {exp_enc[381:0], 2'b11});
    check({tag, "_hold_dec"}, {256'd0, o_decoder_data}, {256'd0, exp_dec});
  endtask

  initial begin
    logic [26:0]  g75;
    logic [26:0]  g753;
    logic [26:0]  g9;
    logic [127:0] rnd;
    logic [383:0] rnd_enc;
    g75  = {9'h000, 9'h005, 9'h007};
    g753 = {9'h003, 9'h005, 9'h007};
    g9   = {9'h000, 9'h19B, 9'h1ED};
    rst = 1'b1;
    en  = 1'b0;
    i_code_rate = 1'b0;
    i_constr_len = 1'b0;
    i_gen_poly_flat = '0;
    i_encoder_data_frame = '0;
    i_decoder_data_frame = '0;

    start("k3_clean", 1'b0, 1'b0, g75, 128'hD, 384'hE87);
    run_frame("k3_clean", 384'hE87, 128'hD, 0, 0, '0);

    start("k3_err", 1'b0, 1'b0, g75, 128'hD, 384'hE97);
    run_frame("k3_err", 384'hE87, 128'hD, 0, 0, '0);

`ifdef ENDEC_RATE3_EN
    start("r3", 1'b1, 1'b0, g753, 128'h1, 384'hEF);
    run_frame("r3", 384'hEF, 128'h1, 0, 0, '0);
`else
    start("r3_off", 1'b1, 1'b0, g753, 128'h1, 384'h37);
    run_frame("r3_off", 384'h37, 128'h1, 0, 0, '0);
`endif

    start("pause", 1'b0, 1'b0, g75, 128'hD, 384'hE87);
    run_frame("pause", 384'hE87, 128'hD, 3, 20, 384'h07);

    start("abort", 1'b0, 1'b0, g75, 128'hD, 384'hE87);
    for (int e = 0; e <= 50; e++) @(posedge sys_clk);
    #1;
    check("abort_mid_enc", o_encoder_data, 384'hE87);
    rst = 1'b1;
    #1;
    check("abort_enc_clr", o_encoder_data, '0);
    check("abort_flags_clr", {382'd0, o_encoder_done, o_decoder_done}, '0);
    start("fresh", 1'b0, 1'b0, g75, 128'h1, 384'h37);
    run_frame("fresh", 384'h37, 128'h1, 0, 0, '0);

    start("k9_zero", 1'b0, 1'b1, g9, 128'h0, 384'h0);
    run_frame("k9_zero", 384'h0, 128'h0, 0, 0, '0);

    rnd = {$urandom, $urandom, $urandom, $urandom};
    rnd_enc = conv_enc(rnd, 9, 2, g9);
    start("k9_rnd", 1'b0, 1'b1, g9, rnd, rnd_enc);
    run_frame("k9_rnd", rnd_enc, rnd, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
